// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO read-side burst consumer.
package fifo_rd_pkg;
    localparam int DATA_W    = 16;
    localparam int USEDW_W   = 7;
    localparam int FILL_FULL = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/fifo_burst_reader_stream_buf2.sv
// Two-entry registered valid/ready buffer carrying data+last. The writer must
// respect the reported occupancy; a push into a full, non-popping buffer is illegal.
module stream_buf2 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        occupancy
);
    logic [DATA_W-1:0] skid_data;
    logic              skid_last;
    logic              pop;

    assign pop = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            skid_data <= '0;
            skid_last <= 1'b0;
        end else begin
            case (occupancy)
                2'd0: begin
                    if (push) begin
                        out_valid <= 1'b1;
                        out_data  <= push_data;
                        out_last  <= push_last;
                        occupancy <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        out_data <= push_data;
                        out_last <= push_last;
                    end else if (push) begin
                        skid_data <= push_data;
                        skid_last <= push_last;
                        occupancy <= 2'd2;
                    end else if (pop) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        occupancy <= 2'd0;
                    end
                end
                default: begin
                    // Head holds while stalled; skid shifts forward on pop.
                    if (pop) begin
                        out_data <= skid_data;
                        out_last <= skid_last;
                        if (push) begin
                            skid_data <= push_data;
                            skid_last <= push_last;
                        end else begin
                            occupancy <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/fifo_burst_reader.sv
// Drains fixed-length bursts from a normal-mode FIFO into a valid/ready stream.
// Optional build macro FIFO_BURST_CHKSUM_EN appends a 16-bit sum word to each burst.
//
// state    | meaning
// ST_IDLE  | waiting for enable and a full burst buffered in the FIFO
// ST_READ  | issuing rdreq until BURST_LEN words requested
// ST_DRAIN | all words requested; emptying buffer until the last word is accepted
import fifo_rd_pkg::*;

module fifo_burst_reader #(
    parameter int BURST_LEN = 64,
    parameter int USEDW_W   = fifo_rd_pkg::USEDW_W,
    parameter int DATA_W    = fifo_rd_pkg::DATA_W
) (
    input  logic               rdclk,
    input  logic               rst,
    input  logic               enable,
    input  logic               rdempty,
    input  logic               rdfull,
    input  logic [USEDW_W-1:0] rdusedw,
    input  logic [DATA_W-1:0]  q,
    output logic               rdreq,
    output logic [DATA_W-1:0]  m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               busy,
    output logic [15:0]        burst_cnt
);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] BURST_N = CNT_W'(BURST_LEN);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  fill;
    logic              rdreq_q;
    logic [1:0]        occ;
    logic [2:0]        credit;
    logic              pop, start, done;
    logic              push, push_last;
    logic [DATA_W-1:0] push_data;

    assign fill   = rdfull ? CNT_W'(FILL_FULL) : CNT_W'(rdusedw);
    assign pop    = m_valid & m_ready;
    // Words already in the buffer plus the one on its way, net of this cycle's pop.
    assign credit = {1'b0, occ} + {2'b00, rdreq_q} - {2'b00, pop};
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge rdclk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        rdreq    = 1'b0;
        start    = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && (fill >= BURST_N)) begin
                    start    = 1'b1;
                    state_nx = ST_READ;
                end
            end
            ST_READ: begin
                rdreq = !rdempty && (issued < BURST_N) && (credit < 3'd2);
                if (issued == BURST_N) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop && m_last) begin
                    done     = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge rdclk or posedge rst) begin
        if (rst) begin
            issued    <= '0;
            rdreq_q   <= 1'b0;
            burst_cnt <= 16'd0;
        end else begin
            rdreq_q <= rdreq;
            if (start)      issued <= '0;
            else if (rdreq) issued <= issued + CNT_W'(1);
            if (done) burst_cnt <= burst_cnt + 16'd1;
        end
    end

`ifdef FIFO_BURST_CHKSUM_EN
    logic [DATA_W-1:0] chksum;
    logic              chk_push;

    // Buffer empty with nothing in flight during DRAIN means every data word is accepted.
    assign chk_push  = (state == ST_DRAIN) && (occ == 2'd0) && !rdreq_q;
    assign push      = rdreq_q | chk_push;
    assign push_data = chk_push ? chksum : q;
    assign push_last = chk_push;

    always_ff @(posedge rdclk or posedge rst) begin
        if (rst)          chksum <= '0;
        else if (start)   chksum <= '0;
        else if (rdreq_q) chksum <= chksum + q;
    end
`else
    logic [CNT_W-1:0] returned;

    assign push      = rdreq_q;
    assign push_data = q;
    assign push_last = (returned == BURST_N - CNT_W'(1));

    always_ff @(posedge rdclk or posedge rst) begin
        if (rst)          returned <= '0;
        else if (start)   returned <= '0;
        else if (rdreq_q) returned <= returned + CNT_W'(1);
    end
`endif

    stream_buf2 #(.DATA_W(DATA_W)) u_buf (
        .clk       (rdclk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .push_last (push_last),
        .out_ready (m_ready),
        .out_valid (m_valid),
        .out_data  (m_data),
        .out_last  (m_last),
        .occupancy (occ)
    );
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural normal-mode FIFO model.
`timescale 1ns/1ps
module tb_fifo_burst_reader;
    localparam int BL = 64;

    logic        rdclk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        rdempty = 1'b1;
    logic        rdfull = 1'b0;
    logic [6:0]  rdusedw = 7'd0;
    logic [15:0] q = 16'd0;
    logic        m_ready = 1'b0;
    logic        rdreq, m_valid, m_last, busy;
    logic [15:0] m_data, burst_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] fifo_q[$];
    logic [15:0] stage_q[$];
    logic [16:0] rx_q[$];
    logic [16:0] exp_q[$];
    logic        force_empty = 1'b0;

    int cyc = 0, rd_total = 0, rd_run = 0, rd_run_max = 0, acc_total = 0, occ_max = 0;
    int stall_err = 0, empty_rd_err = 0, first_busy = -1, first_valid = -1, first_rd = -1;
    logic        prev_stall = 1'b0, prev_last = 1'b0, prev_rd = 1'b0;
    logic [15:0] prev_data = 16'd0;

    always #5 rdclk = ~rdclk;

    fifo_burst_reader #(.BURST_LEN(BL)) dut (
        .rdclk(rdclk), .rst(rst), .enable(enable), .rdempty(rdempty), .rdfull(rdfull),
        .rdusedw(rdusedw), .q(q), .rdreq(rdreq), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .burst_cnt(burst_cnt)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic set_flags();
        int n;
        n = fifo_q.size();
        rdusedw = 7'(n);
        rdfull  = (n >= 128);
        rdempty = (n == 0) || force_empty;
    endtask

    // One clock: sample at negedge, then FIFO model updates 1 ns after posedge.
    task automatic tick();
        int occ_m;
        @(negedge rdclk);
        cyc++;
        if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stall_err++;
        occ_m = rd_total - (prev_rd ? 1 : 0) - acc_total;
        if (occ_m > occ_max) occ_max = occ_m;
        if (rdreq && rdempty) empty_rd_err++;
        if (busy && first_busy < 0) first_busy = cyc;
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (rdreq && first_rd < 0) first_rd = cyc;
        if (m_valid && m_ready) begin
            rx_q.push_back({m_last, m_data});
            acc_total++;
        end
        rd_run = rdreq ? rd_run + 1 : 0;
        if (rd_run > rd_run_max) rd_run_max = rd_run;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        prev_rd    = rdreq;
        if (rdreq) rd_total++;
        @(posedge rdclk);
        #1;
        if (prev_rd && fifo_q.size() > 0) q = fifo_q.pop_front();
        set_flags();
    endtask

    task automatic clear_stats();
        rx_q.delete(); exp_q.delete(); stage_q.delete();
        rd_total = 0; rd_run = 0; rd_run_max = 0; acc_total = 0; occ_max = 0;
        stall_err = 0; empty_rd_err = 0; first_busy = -1; first_valid = -1; first_rd = -1;
        prev_stall = 1'b0; prev_rd = 1'b0;
    endtask

    task automatic make_burst(input logic [15:0] base, input logic [15:0] step);
        logic [15:0] w;
`ifdef FIFO_BURST_CHKSUM_EN
        logic [15:0] sum;
        sum = 16'd0;
`endif
        w = base;
        for (int i = 0; i < BL; i++) begin
            stage_q.push_back(w);
`ifdef FIFO_BURST_CHKSUM_EN
            sum = sum + w;
            exp_q.push_back({1'b0, w});
`else
            exp_q.push_back({(i == BL - 1), w});
`endif
            w = w + step;
        end
`ifdef FIFO_BURST_CHKSUM_EN
        exp_q.push_back({1'b1, sum});
`endif
    endtask

    task automatic push_stage(input int n);
        for (int i = 0; i < n; i++) if (stage_q.size() > 0) fifo_q.push_back(stage_q.pop_front());
        set_flags();
    endtask

    task automatic run_burst(input int budget, input logic toggle, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (toggle) m_ready = ~m_ready;
            if (rx_q.size() >= exp_q.size() && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int count_errs();
        int e;
        e = 0;
        if (rx_q.size() != exp_q.size()) e++;
        foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) e++;
        return e;
    endfunction

    task automatic test_reset();
        #1 rst = 1'b1;
        #3;
        n_cmp++; if (rdreq !== 1'b0)      begin n_err++; $display("FAIL rst_rdreq: got %b want 0", rdreq); end
        n_cmp++; if (m_valid !== 1'b0)    begin n_err++; $display("FAIL rst_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_last !== 1'b0)     begin n_err++; $display("FAIL rst_last: got %b want 0", m_last); end
        n_cmp++; if (m_data !== 16'h0)    begin n_err++; $display("FAIL rst_data: got %h want 0000", m_data); end
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (burst_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", burst_cnt); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic ok;
        clear_stats();
        m_ready = 1'b1; enable = 1'b1;
        make_burst(16'h0000, 16'h0001);
        push_stage(BL);
        run_burst(400, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1)        begin n_err++; $display("FAIL basic_done: got %b want 1", ok); end
        n_cmp++; if (rd_run_max != 64)   begin n_err++; $display("FAIL basic_rdreq_run: got %0d want 64", rd_run_max); end
        n_cmp++; if (rd_total != 64)     begin n_err++; $display("FAIL basic_rdreq_total: got %0d want 64", rd_total); end
        n_cmp++; if (count_errs() != 0)  begin n_err++; $display("FAIL basic_stream: got %0d bad words want 0", count_errs()); end
        n_cmp++; if (first_valid - first_busy != 2) begin n_err++; $display("FAIL basic_latency: got %0d want 2", first_valid - first_busy); end
        n_cmp++; if (first_rd != first_busy) begin n_err++; $display("FAIL basic_first_rd: got %0d want %0d", first_rd, first_busy); end
        n_cmp++; if (burst_cnt !== 16'd1) begin n_err++; $display("FAIL basic_cnt: got %0d want 1", burst_cnt); end
    endtask

    task automatic test_threshold();
        logic ok;
        int push_cyc;
        clear_stats();
        make_burst(16'h0100, 16'h0001);
        push_stage(BL - 1);
        repeat (10) tick();
        n_cmp++; if (rd_total != 0)    begin n_err++; $display("FAIL thr_no_rdreq: got %0d want 0", rd_total); end
        n_cmp++; if (first_busy != -1) begin n_err++; $display("FAIL thr_no_busy: got %0d want -1", first_busy); end
        push_stage(1);
        push_cyc = cyc + 1;
        run_burst(400, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1)       begin n_err++; $display("FAIL thr_done: got %b want 1", ok); end
        n_cmp++; if (first_rd - push_cyc != 1) begin n_err++; $display("FAIL thr_start: got %0d want 1", first_rd - push_cyc); end
        n_cmp++; if (count_errs() != 0) begin n_err++; $display("FAIL thr_stream: got %0d bad words want 0", count_errs()); end
        n_cmp++; if (burst_cnt !== 16'd2) begin n_err++; $display("FAIL thr_cnt: got %0d want 2", burst_cnt); end
    endtask

    task automatic test_backpressure();
        logic ok;
        clear_stats();
        m_ready = 1'b1;
        make_burst(16'h0200, 16'h0001);
        push_stage(BL);
        tick(); tick();
        enable = 1'b0;
        run_burst(600, 1'b1, ok);
        m_ready = 1'b1;
        n_cmp++; if (ok !== 1'b1)       begin n_err++; $display("FAIL bp_done: got %b want 1", ok); end
        n_cmp++; if (count_errs() != 0) begin n_err++; $display("FAIL bp_stream: got %0d bad words want 0", count_errs()); end
        n_cmp++; if (stall_err != 0)    begin n_err++; $display("FAIL bp_stable: got %0d changes want 0", stall_err); end
        n_cmp++; if (occ_max > 2)       begin n_err++; $display("FAIL bp_occupancy: got %0d want <=2", occ_max); end
        n_cmp++; if (burst_cnt !== 16'd3) begin n_err++; $display("FAIL bp_cnt: got %0d want 3", burst_cnt); end
        enable = 1'b1;
    endtask

    task automatic test_empty_gap();
        logic ok;
        int gap_rd;
        clear_stats();
        make_burst(16'h0300, 16'h0001);
        push_stage(BL);
        for (int i = 0; i < 50 && rd_total < 10; i++) tick();
        force_empty = 1'b1;
        set_flags();
        gap_rd = rd_total;
        repeat (5) tick();
        n_cmp++; if (rd_total - gap_rd != 0) begin n_err++; $display("FAIL gap_rdreq: got %0d want 0", rd_total - gap_rd); end
        force_empty = 1'b0;
        set_flags();
        run_burst(400, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1)       begin n_err++; $display("FAIL gap_done: got %b want 1", ok); end
        n_cmp++; if (count_errs() != 0) begin n_err++; $display("FAIL gap_stream: got %0d bad words want 0", count_errs()); end
        n_cmp++; if (rd_total != 64)    begin n_err++; $display("FAIL gap_total: got %0d want 64", rd_total); end
        n_cmp++; if (empty_rd_err != 0) begin n_err++; $display("FAIL gap_rd_on_empty: got %0d want 0", empty_rd_err); end
        n_cmp++; if (burst_cnt !== 16'd4) begin n_err++; $display("FAIL gap_cnt: got %0d want 4", burst_cnt); end
    endtask

    task automatic test_chksum();
        logic ok;
        logic [16:0] w;
        clear_stats();
        make_burst(16'h0401, 16'h0000);
        push_stage(BL);
        run_burst(400, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1)       begin n_err++; $display("FAIL chk_done: got %b want 1", ok); end
        n_cmp++; if (count_errs() != 0) begin n_err++; $display("FAIL chk_stream: got %0d bad words want 0", count_errs()); end
`ifdef FIFO_BURST_CHKSUM_EN
        w = (rx_q.size() > 64) ? rx_q[64] : 17'h0;
        n_cmp++; if (rx_q.size() != 65)  begin n_err++; $display("FAIL chk_len: got %0d want 65", rx_q.size()); end
        n_cmp++; if (w !== 17'h10040)    begin n_err++; $display("FAIL chk_word: got %h want 10040", w); end
        w = (rx_q.size() > 63) ? rx_q[63] : 17'h1ffff;
        n_cmp++; if (w !== 17'h00401)    begin n_err++; $display("FAIL chk_data_last: got %h want 00401", w); end
`else
        w = (rx_q.size() > 63) ? rx_q[63] : 17'h0;
        n_cmp++; if (rx_q.size() != 64)  begin n_err++; $display("FAIL chk_len: got %0d want 64", rx_q.size()); end
        n_cmp++; if (w !== 17'h10401)    begin n_err++; $display("FAIL chk_last_word: got %h want 10401", w); end
`endif
        n_cmp++; if (burst_cnt !== 16'd5) begin n_err++; $display("FAIL chk_cnt: got %0d want 5", burst_cnt); end
    endtask

    task automatic test_reset_mid();
        logic ok;
        clear_stats();
        make_burst(16'h0400, 16'h0001);
        push_stage(BL);
        for (int i = 0; i < 100 && acc_total < 20; i++) tick();
        n_cmp++; if (acc_total != 20) begin n_err++; $display("FAIL rmid_reach: got %0d want 20", acc_total); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (rdreq !== 1'b0)      begin n_err++; $display("FAIL rmid_rdreq: got %b want 0", rdreq); end
        n_cmp++; if (m_valid !== 1'b0)    begin n_err++; $display("FAIL rmid_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_last !== 1'b0)     begin n_err++; $display("FAIL rmid_last: got %b want 0", m_last); end
        n_cmp++; if (m_data !== 16'h0)    begin n_err++; $display("FAIL rmid_data: got %h want 0000", m_data); end
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_cmp++; if (burst_cnt !== 16'd0) begin n_err++; $display("FAIL rmid_cnt: got %0d want 0", burst_cnt); end
        tick(); tick();
        rst = 1'b0;
        fifo_q.delete();
        clear_stats();
        make_burst(16'h0500, 16'h0001);
        push_stage(BL);
        run_burst(400, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1)       begin n_err++; $display("FAIL rmid_done: got %b want 1", ok); end
        n_cmp++; if (count_errs() != 0) begin n_err++; $display("FAIL rmid_stream: got %0d bad words want 0", count_errs()); end
        n_cmp++; if (burst_cnt !== 16'd1) begin n_err++; $display("FAIL rmid_cnt_after: got %0d want 1", burst_cnt); end
    endtask

    initial begin
        set_flags();
        test_reset();
        test_basic();
        test_threshold();
        test_backpressure();
        test_empty_gap();
        test_chksum();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
